// File: rtl/csa_pkg.sv
// ----------------------------------------------------------------------------
// csa_pkg
//   Shared defaults for the pipelined carry-select adder.
//   CSA_N_DEFAULT     : default operand/sum width.
//   CSA_BLOCK_DEFAULT : default bits per carry-select block (one block/stage).
//   csa_stages()      : number of pipeline stages for a given width/block size.
//   Related build macro: CSA_SUB_EN (adds the subtract port on the top).
// ----------------------------------------------------------------------------
package csa_pkg;

   localparam int CSA_N_DEFAULT     = 32;
   localparam int CSA_BLOCK_DEFAULT = 8;

   // Width is required to be a whole number of blocks.
   function automatic int csa_stages(input int n, input int block);
      return n / block;
   endfunction

endpackage

// File: rtl/csa_block.sv
// ----------------------------------------------------------------------------
// csa_block
//   Combinational carry-select block: two ripple-carry sums of the block
//   operands (carry-in 0 and carry-in 1), one selected by the incoming carry.
//   Ports:
//     i_a, i_b : W-bit block operands
//     i_cin    : carry into the block (selects the precomputed sum)
//     o_sum    : W-bit block sum
//     o_cout   : carry out of the block
//   Build macro CSA_SUB_EN has no effect here.
// ----------------------------------------------------------------------------
module csa_block
   import csa_pkg::*;
#(
   parameter int W = CSA_BLOCK_DEFAULT
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   logic [W-1:0] w_sum0;
   logic [W-1:0] w_sum1;
   logic         w_cout0;
   logic         w_cout1;

   // Both ripple chains run in parallel; carries are block-local variables.
   always_comb begin
      logic c0;
      logic c1;
      c0     = 1'b0;
      c1     = 1'b1;
      w_sum0 = '0;
      w_sum1 = '0;
      for (int unsigned i = 0; i < W; i++) begin
         w_sum0[i] = i_a[i] ^ i_b[i] ^ c0;
         w_sum1[i] = i_a[i] ^ i_b[i] ^ c1;
         c0 = (i_a[i] & i_b[i]) | (c0 & (i_a[i] ^ i_b[i]));
         c1 = (i_a[i] & i_b[i]) | (c1 & (i_a[i] ^ i_b[i]));
      end
      w_cout0 = c0;
      w_cout1 = c1;
   end

   assign o_sum  = i_cin ? w_sum1  : w_sum0;
   assign o_cout = i_cin ? w_cout1 : w_cout0;

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// ----------------------------------------------------------------------------
// pipelined_carry_select_adder
//   N-bit adder split into STAGES = N/BLOCK carry-select blocks, one block per
//   pipeline stage, with a valid/ready handshake on both sides.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid / in_ready : input handshake (in_ready = pipeline advance)
//     A, B, cin           : operands and carry into bit 0
//     sub                 : (only with CSA_SUB_EN) 1 = A + ~B + 1, cin ignored
//     out_valid/out_ready : output handshake
//     S, cout, OF         : sum, carry out of bit N-1, two's-complement overflow
//   Build macro CSA_SUB_EN adds the sub port; without it sub behaves as 0.
//   Latency is STAGES cycles; all stages advance together when the output
//   slot is empty or being consumed.
// ----------------------------------------------------------------------------
module pipelined_carry_select_adder
   import csa_pkg::*;
#(
   parameter int N     = CSA_N_DEFAULT,
   parameter int BLOCK = CSA_BLOCK_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         cin,
`ifdef CSA_SUB_EN
   input  logic         sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] S,
   output logic         cout,
   output logic         OF
);

   localparam int STAGES = csa_stages(N, BLOCK);
   localparam int LAST   = STAGES - 1;

   // Per-stage registers: valid bit, block carry, accumulated sum bits and
   // the effective operands travelling with the transaction.
   logic         r_vld   [STAGES];
   logic         r_carry [STAGES];
   logic [N-1:0] r_sum   [STAGES];
   logic [N-1:0] r_a     [STAGES];
   logic [N-1:0] r_b     [STAGES];

   // Inputs seen by each stage's logic.
   logic         w_vld_in [STAGES];
   logic         w_c_in   [STAGES];
   logic [N-1:0] w_sum_in [STAGES];
   logic [N-1:0] w_a_in   [STAGES];
   logic [N-1:0] w_b_in   [STAGES];

   // Results of each stage's logic.
   logic [BLOCK-1:0] w_blk_sum [STAGES];
   logic             w_carry   [STAGES];
   logic [N-1:0]     w_sum     [STAGES];

   logic         w_sub;
   logic [N-1:0] w_b_eff;
   logic         w_cin_eff;
   logic         w_adv;

`ifdef CSA_SUB_EN
   assign w_sub = sub;
`else
   assign w_sub = 1'b0;
`endif

   // Subtraction folds into addition of ~B with a forced carry-in of 1.
   assign w_b_eff   = w_sub ? ~B : B;
   assign w_cin_eff = w_sub | cin;

   assign w_adv    = ~out_valid | out_ready;
   assign in_ready = w_adv;

   always_comb begin
      w_vld_in[0] = in_valid;
      w_c_in[0]   = w_cin_eff;
      w_sum_in[0] = '0;
      w_a_in[0]   = A;
      w_b_in[0]   = w_b_eff;
      for (int unsigned k = 1; k < STAGES; k++) begin
         w_vld_in[k] = r_vld[k-1];
         w_c_in[k]   = r_carry[k-1];
         w_sum_in[k] = r_sum[k-1];
         w_a_in[k]   = r_a[k-1];
         w_b_in[k]   = r_b[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [N-1:0] w_blk_ext;

      csa_block #(
         .W (BLOCK)
      ) u_blk (
         .i_a    (w_a_in[k][k*BLOCK +: BLOCK]),
         .i_b    (w_b_in[k][k*BLOCK +: BLOCK]),
         .i_cin  (w_c_in[k]),
         .o_sum  (w_blk_sum[k]),
         .o_cout (w_carry[k])
      );

      // Bits of block k are still zero in the incoming partial sum, so the
      // new block can be OR-ed into place.
      assign w_blk_ext = N'(w_blk_sum[k]);
      assign w_sum[k]  = w_sum_in[k] | (w_blk_ext << (k * BLOCK));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_vld[k]   <= 1'b0;
            r_carry[k] <= 1'b0;
            r_sum[k]   <= '0;
            r_a[k]     <= '0;
            r_b[k]     <= '0;
         end
      end else if (w_adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_vld[k]   <= w_vld_in[k];
            r_carry[k] <= w_carry[k];
            r_sum[k]   <= w_sum[k];
            r_a[k]     <= w_a_in[k];
            r_b[k]     <= w_b_in[k];
         end
      end
   end

   assign out_valid = r_vld[LAST];
   assign S         = r_sum[LAST];
   assign cout      = r_carry[LAST];
   assign OF        = (r_sum[LAST][N-1] ^ r_a[LAST][N-1]) &
                      ~(r_a[LAST][N-1] ^ r_b[LAST][N-1]);

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// ----------------------------------------------------------------------------
// tb_pipelined_carry_select_adder
//   Bench for pipelined_carry_select_adder at N=32, BLOCK=8 (latency 4).
//   With CSA_SUB_EN defined, the subtract vectors are added as well.
// ----------------------------------------------------------------------------
module tb_pipelined_carry_select_adder;

   localparam int W   = 32;
   localparam int LAT = 4;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         cout;
      logic         of;
   } vec_t;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         of;
   } res_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         cin;
`ifdef CSA_SUB_EN
   logic         sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] S;
   logic         cout;
   logic         OF;

   int   n_cmp;
   int   n_err;
   int   n_out;
   vec_t vecs[$];
   vec_t txq[$];
   res_t exp_q[$];

   pipelined_carry_select_adder #(
      .N     (W),
      .BLOCK (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .cin       (cin),
`ifdef CSA_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .cout      (cout),
      .OF        (OF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: {cout,S} = A + Beff + Ceff, OF from the sign bits.
   function automatic res_t model(input vec_t v);
      res_t         r;
      logic [W-1:0] be;
      logic         ce;
      be = v.sub ? ~v.b : v.b;
      ce = v.sub ? 1'b1 : v.cin;
      {r.cout, r.s} = {1'b0, v.a} + {1'b0, be} + {{W{1'b0}}, ce};
      r.of = (r.s[W-1] ^ v.a[W-1]) & ~(v.a[W-1] ^ be[W-1]);
      return r;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      v.a    = $urandom;
      v.b    = $urandom;
      v.cin  = 1'($urandom_range(1, 0));
`ifdef CSA_SUB_EN
      v.sub  = 1'($urandom_range(1, 0));
`else
      v.sub  = 1'b0;
`endif
      v.s    = '0;
      v.cout = 1'b0;
      v.of   = 1'b0;
      return v;
   endfunction

   task automatic drive(input vec_t v, input logic vld);
      in_valid = vld;
      A        = v.a;
      B        = v.b;
      cin      = v.cin;
`ifdef CSA_SUB_EN
      sub      = v.sub;
`endif
   endtask

   // One clock of the scoreboarded handshake: present head of txq, score any
   // output transfer, record any input acceptance, then advance past the edge.
   task automatic step();
      logic acc;
      logic xfer;
      res_t e;
      vec_t idle;
      idle = '{default: '0};
      if (txq.size() > 0) drive(txq[0], 1'b1);
      else                drive(idle, 1'b0);
      #1;
      acc  = in_valid & in_ready;
      xfer = out_valid & out_ready;
      if (xfer) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", {32'h0, S}, 64'hDEAD_DEAD_DEAD_DEAD);
         end else begin
            e = exp_q.pop_front();
            chk("seq_S", {32'h0, S}, {32'h0, e.s});
            chk("seq_cout_of", {62'h0, cout, OF}, {62'h0, e.cout, e.of});
            n_out++;
         end
      end
      if (acc) begin
         exp_q.push_back(model(txq[0]));
         void'(txq.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   // Single transaction, checked against hand-computed values and latency.
   task automatic run_single(input vec_t v, input string tag);
      int lat;
      drive(v, 1'b1);
      out_ready = 1'b1;
      #1;
      chk({tag, "_in_ready"}, {63'h0, in_ready}, 64'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(LAT));
      chk({tag, "_S"}, {32'h0, S}, {32'h0, v.s});
      chk({tag, "_cout"}, {63'h0, cout}, {63'h0, v.cout});
      chk({tag, "_OF"}, {63'h0, OF}, {63'h0, v.of});
      @(posedge clk);
      #1;
   endtask

   initial begin
      res_t snap;
      int   k;
      n_cmp = 0;
      n_err = 0;
      n_out = 0;

      //            a             b             cin   sub   s             cout  of
      vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1});
      vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0});
      vecs.push_back('{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0});
      vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1});
      vecs.push_back('{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
      vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0});
      vecs.push_back('{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0});
`ifdef CSA_SUB_EN
      vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
      vecs.push_back('{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
`endif

      // Reset state
      rst       = 1'b1;
      out_ready = 1'b0;
      drive('{default: '0}, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
      chk("rst_S_cout_OF", {30'h0, S, cout, OF}, 64'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed table
      foreach (vecs[i]) run_single(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back: 8 inputs, results on cycles 4..11 in order
      out_ready = 1'b1;
      n_out = 0;
      repeat (8) txq.push_back(rnd_vec());
      for (int i = 1; i <= 14; i++) begin
         step();
         chk($sformatf("b2b_valid_c%0d", i), {63'h0, out_valid},
             {63'h0, (i >= LAT && i <= LAT + 7) ? 1'b1 : 1'b0});
      end
      chk("b2b_count", 64'(n_out), 64'd8);

      // Stall with full pipeline, then release
      out_ready = 1'b0;
      n_out = 0;
      repeat (6) txq.push_back(rnd_vec());
      repeat (LAT) step();
      chk("stall_out_valid", {63'h0, out_valid}, 64'h1);
      chk("stall_accepted", 64'(txq.size()), 64'd2);
      snap = '{s: S, cout: cout, of: OF};
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("stall_in_ready_c%0d", i), {63'h0, in_ready}, 64'h0);
         chk($sformatf("stall_frozen_c%0d", i), {29'h0, out_valid, S, cout, OF},
             {29'h0, 1'b1, snap.s, snap.cout, snap.of});
      end
      out_ready = 1'b1;
      k = 0;
      while ((txq.size() > 0 || exp_q.size() > 0) && k < 40) begin
         step();
         k++;
      end
      chk("stall_drain_left", 64'(txq.size() + exp_q.size()), 64'd0);
      chk("stall_count", 64'(n_out), 64'd6);
      repeat (3) step();
      chk("stall_no_dup", 64'(n_out), 64'd6);

      // Reset with 3 transactions in flight
      n_out = 0;
      repeat (3) txq.push_back(rnd_vec());
      repeat (3) step();
      chk("mid_pre_valid", {63'h0, out_valid}, 64'h0);
      rst = 1'b1;
      step();
      chk("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
      chk("mid_rst_S_cout_OF", {30'h0, S, cout, OF}, 64'h0);
      exp_q.delete();
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("post_rst_idle_c%0d", i), {63'h0, out_valid}, 64'h0);
      end
      run_single(vecs[0], "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipelined_carry_select_adder.md
PIPELINED_CARRY_SELECT_ADDER -- requirements
Module: pipelined_carry_select_adder

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/sum width in bits.
REQ-002 SHALL have parameter BLOCK, default 8, meaning bits per carry-select block; N SHALL be an integer multiple of BLOCK (STAGES = N/BLOCK).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set A/B/cin is presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 A, B  input  N each  operands.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 out_valid  output  1  S/cout/OF hold a completed result.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 S  output  N  sum.
REQ-012 cout  output  1  carry out of bit N-1.
REQ-013 OF  output  1  two's-complement overflow.

Function
REQ-014 Stage k (k=0..STAGES-1) SHALL compute block k, bits [k*BLOCK +: BLOCK], as two ripple sums (carry-in 0 and 1), selecting sum and block carry by the carry registered from stage k-1 (stage 0 uses cin).
REQ-015 Operand bits for later blocks SHALL travel through delay registers with the transaction; completed sum bits SHALL travel with it to the output.
REQ-016 Result SHALL equal {cout,S} = A + B + cin modulo 2^(N+1); OF = (S[N-1]^A[N-1]) & ~(A[N-1]^B[N-1]) on effective operands.
REQ-017 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-018 Pipeline SHALL advance globally when adv = ~out_valid | out_ready; in_ready = adv.
REQ-019 Latency SHALL be exactly STAGES cycles from accepted input to out_valid with no stall; throughput one result per cycle under continuous out_ready.
REQ-020 When adv=0 every stage register, including per-stage valid bits, SHALL hold; S/cout/OF SHALL remain stable while out_valid&~out_ready.
REQ-021 Bubbles (in_valid=0 while adv=1) SHALL propagate as invalid slots; no result is produced for them.
REQ-022 Simultaneous output transfer and input acceptance in one cycle SHALL be lossless.

Reset
REQ-023 While rst=1 all per-stage valid bits and out_valid SHALL be 0; S, cout, OF SHALL be 0.
REQ-024 Reset mid-operation SHALL discard all in-flight transactions; first post-reset input emerges after STAGES cycles.
REQ-025 in_ready SHALL be 1 during and after reset (out_valid=0).

Configuration
REQ-026 Macro CSA_SUB_EN SHALL, when defined, add input port sub (1 bit, sampled with A/B); sub=1 computes A + ~B + 1 (cin ignored), OF using ~B.
REQ-027 Without CSA_SUB_EN the sub port SHALL be absent and behaviour SHALL equal sub=0.

Structure
REQ-028 Package csa_pkg SHALL hold default N, default BLOCK and the STAGES derivation function.
REQ-029 Sub-module csa_block (BLOCK-wide dual ripple plus selection, combinational) SHALL be instantiated once per stage.

Verification (N=32, BLOCK=8, latency 4)
REQ-030 A=0x7FFFFFFF, B=1, cin=0 -> 4 cycles later S=0x80000000, cout=0, OF=1.
REQ-031 A=0xFFFFFFFF, B=0, cin=1 -> S=0x00000000, cout=1, OF=0 (carry ripples through all blocks).
REQ-032 8 back-to-back random inputs, out_ready=1 -> 8 consecutive out_valid cycles starting cycle 4, results in order, matching reference sum.
REQ-033 out_ready=0 for 5 cycles with pipeline full -> in_ready=0, S/cout/OF frozen; on release, no loss or duplication.
REQ-034 rst asserted with 3 transactions in flight -> out_valid=0 next cycle; no stale result after release.
REQ-035 CSA_SUB_EN defined, A=5, B=7, sub=1 -> S=0xFFFFFFFE, cout=0, OF=0; A=0x80000000, B=1, sub=1 -> S=0x7FFFFFFF, OF=1.
